// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage pipeline stall/flush sequencer.
//   state_t          : sequencer state (RUN = normal flow, DROP = discarding a
//                      wrong-path fetch that is still in flight)
//   REG_X0           : architectural zero register, never a real hazard source
//   *_DEF constants  : default parameter values used by pipeline_ctrl
// Optional feature macro used by the top: PIPELINE_CTRL_PERF_EN
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int WAIT_TIMEOUT_DEF = 255;
    localparam int TO_WIDTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF    = 32;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. Flags when the instruction in E is
// a load whose destination matches either source operand of the instruction
// in D. Kept separate so the same compare can feed forwarding logic later.
// Ports:
//   i_rs1_d     in  5  source register 1 of the instruction in D
//   i_rs2_d     in  5  source register 2 of the instruction in D
//   i_rd_e      in  5  destination register of the instruction in E
//   i_load_e    in  1  instruction in E is a load
//   o_load_use  out 1  dependent instruction in D must wait one cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    input  logic [4:0] i_rd_e,
    input  logic       i_load_e,
    output logic       o_load_use
);

    logic w_rdValid;
    logic w_srcMatch;

    // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
    assign w_rdValid  = (i_rd_e != REG_X0);
    assign w_srcMatch = (i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d);
    assign o_load_use = i_load_e & w_rdValid & w_srcMatch;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Drives the enable
// and synchronous-clear inputs of the pipeline registers, resolving load-use
// hazards, taken-branch redirects, fetch wait states and data-memory wait
// states. A two-state FSM tracks a stale fetch still in flight after a
// redirect so that the returning wrong-path instruction is discarded.
// Outputs are combinational from the state and inputs.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   defined   : stall_cycles / flush_events are saturating event counters
//   undefined : both ports are tied to zero, no counter flops
//
// Ports:
//   clk            in  1          system clock, rising edge
//   reset          in  1          synchronous, active-high
//   rs1_d, rs2_d   in  5          source registers of the instruction in D
//   rd_e           in  5          destination register of the instruction in E
//   load_e         in  1          instruction in E is a load
//   pc_src_e       in  1          taken branch/jump resolved in E
//   imem_ready_f   in  1          instruction memory returns data this cycle
//   mem_req_m      in  1          load/store access active in M
//   dmem_ready_m   in  1          data memory completes the M access
//   en_f .. en_w   out 1          PC, IF/ID, ID/EX, EX/MEM, MEM/WB enables
//   flush_d/e/w    out 1          clear IF/ID, ID/EX, MEM/WB
//   dmem_timeout   out 1          sticky data-memory timeout flag
//   stall_cycles   out CNT_WIDTH  cycles with PC held (optional feature)
//   flush_events   out CNT_WIDTH  cycles with ID/EX cleared (optional feature)
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
    parameter int TO_WIDTH     = TO_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rd_e,
    input  logic                 load_e,
    input  logic                 pc_src_e,
    input  logic                 imem_ready_f,
    input  logic                 mem_req_m,
    input  logic                 dmem_ready_m,
    output logic                 en_f,
    output logic                 en_d,
    output logic                 en_e,
    output logic                 en_m,
    output logic                 en_w,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_w,
    output logic                 dmem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    localparam logic [TO_WIDTH:0] LP_TIMEOUT = (TO_WIDTH+1)'(WAIT_TIMEOUT);

    state_t r_state;
    state_t w_stateNext;

    logic w_loadUse;
    logic w_dstall;
    logic w_redirect;

    logic [TO_WIDTH-1:0] r_waitCnt;
    logic [TO_WIDTH:0]   w_waitCntInc;
    logic                r_timeout;

    hazard_detect u_hazard_detect (
        .i_rs1_d    (rs1_d),
        .i_rs2_d    (rs2_d),
        .i_rd_e     (rd_e),
        .i_load_e   (load_e),
        .o_load_use (w_loadUse)
    );

    // A data-memory wait freezes everything up to M; a redirect arriving in
    // that cycle is held in the frozen E stage and acted on once M completes.
    assign w_dstall   = mem_req_m & ~dmem_ready_m;
    assign w_redirect = pc_src_e & ~w_dstall;

    // State register; reset abandons any stale fetch because the instruction
    // memory is reset alongside this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state. DROP is entered when a redirect is taken while the old
    // fetch has not returned yet, and left when that stale fetch returns.
    // A further redirect during DROP keeps the sequencer discarding.
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            RUN: begin
                if (w_redirect && !imem_ready_f) begin
                    w_stateNext = DROP;
                end
            end
            DROP: begin
                if (w_redirect) begin
                    w_stateNext = DROP;
                end else if (imem_ready_f) begin
                    w_stateNext = RUN;
                end
            end
            default: w_stateNext = RUN;
        endcase
    end

    // Output decode. In RUN the first matching hazard wins. In DROP fetch is
    // always held and D always cleared, while D..W still react to data waits,
    // redirects and load-use exactly as in RUN.
    always_comb begin
        en_f    = 1'b1;
        en_d    = 1'b1;
        en_e    = 1'b1;
        en_m    = 1'b1;
        en_w    = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_dstall) begin
                    en_f    = 1'b0;
                    en_d    = 1'b0;
                    en_e    = 1'b0;
                    en_m    = 1'b0;
                    flush_w = 1'b1;
                end else if (pc_src_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (w_loadUse) begin
                    en_f    = 1'b0;
                    en_d    = 1'b0;
                    flush_e = 1'b1;
                end else if (!imem_ready_f) begin
                    en_f    = 1'b0;
                    flush_d = 1'b1;
                end
            end
            DROP: begin
                en_f    = 1'b0;
                flush_d = 1'b1;
                if (w_dstall) begin
                    en_d    = 1'b0;
                    en_e    = 1'b0;
                    en_m    = 1'b0;
                    flush_w = 1'b1;
                end else if (pc_src_e) begin
                    flush_e = 1'b1;
                end else if (w_loadUse) begin
                    en_d    = 1'b0;
                    flush_e = 1'b1;
                end
            end
            default: begin
                en_f    = 1'b0;
                flush_d = 1'b1;
            end
        endcase
    end

    // Consecutive data-wait counter. It saturates at all-ones; the flag is
    // set on the edge where the count reaches the threshold and stays set
    // until reset. Pipeline control never looks at the flag.
    assign w_waitCntInc = {1'b0, r_waitCnt} + {{TO_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else if (w_dstall) begin
            if (!w_waitCntInc[TO_WIDTH]) begin
                r_waitCnt <= w_waitCntInc[TO_WIDTH-1:0];
            end
            if (w_waitCntInc >= LP_TIMEOUT) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

    assign dmem_timeout = r_timeout;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] r_stallCycles;
    logic [CNT_WIDTH-1:0] r_flushEvents;
    logic [CNT_WIDTH:0]   w_stallInc;
    logic [CNT_WIDTH:0]   w_flushInc;

    assign w_stallInc = {1'b0, r_stallCycles} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_flushInc = {1'b0, r_flushEvents} + {{CNT_WIDTH{1'b0}}, 1'b1};

    // Saturating performance counters: PC-held cycles and ID/EX clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            if (!en_f && !w_stallInc[CNT_WIDTH]) begin
                r_stallCycles <= w_stallInc[CNT_WIDTH-1:0];
            end
            if (flush_e && !w_flushInc[CNT_WIDTH]) begin
                r_flushEvents <= w_flushInc[CNT_WIDTH-1:0];
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_events = r_flushEvents;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
